// File: rtl/idli_sqi_resp.sv
// SQI memory responder: decodes a quad-serial READ/WRITE command stream and serves a byte array.
// Optional mode register (RDMR/WRMR, BYTE/PAGE/SEQ addressing) enabled by IDLI_SQI_RESP_MODE_REG_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for cs_n low; first nibble is command high half
// S_CMD   | command low half, decode operation
// S_ADDR  | shifting in ADDR_W/4 address nibbles
// S_DUMMY | turnaround nibbles before read data
// S_RD    | driving read data, high nibble then low nibble
// S_WR    | collecting write data, store on low nibble
// S_IGN   | unknown command, idle until cs_n high
module idli_sqi_resp #(
  parameter int ADDR_W        = 16,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sqi_cs_n,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_sio_en
);

  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
  localparam logic [7:0] MODE_SEQ   = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGN
  } state_t;

  typedef enum logic [1:0] {
    OP_RD, OP_WR, OP_RDMR, OP_WRMR
  } op_t;

  state_t            r_state, w_state_nxt;
  op_t               r_op, w_op_cmd;
  logic              w_cmd_ok;
  logic [7:0]        w_cmd;
  logic [3:0]        r_cmd_hi;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr_inc;
  logic              r_half;
  logic [3:0]        r_wdata_hi;
  logic [3:0]        r_sio;
  logic              r_sio_en;
  logic [3:0]        w_sio_nxt;
  logic              w_sio_en_nxt;
  logic              w_mem_we, w_mode_we, w_adv;
  logic [7:0]        w_mode;
  logic [7:0]        w_rd_byte;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  assign w_cmd = {r_cmd_hi, i_sqi_sio};

  always_comb begin
    w_cmd_ok = 1'b0;
    w_op_cmd = OP_RD;
    case (w_cmd)
      8'h03: begin w_cmd_ok = 1'b1; w_op_cmd = OP_RD;   end
      8'h02: begin w_cmd_ok = 1'b1; w_op_cmd = OP_WR;   end
`ifdef IDLI_SQI_RESP_MODE_REG_EN
      8'h05: begin w_cmd_ok = 1'b1; w_op_cmd = OP_RDMR; end
      8'h01: begin w_cmd_ok = 1'b1; w_op_cmd = OP_WRMR; end
`endif
      default: ;
    endcase
  end

`ifdef IDLI_SQI_RESP_MODE_REG_EN
  logic [7:0] r_mode;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_mode <= MODE_SEQ;
    else if (w_mode_we) r_mode <= {r_wdata_hi, i_sqi_sio};
  end
  assign w_mode = r_mode;
`else
  logic w_unused_mode_we;
  assign w_unused_mode_we = w_mode_we;
  assign w_mode = MODE_SEQ;
`endif

  // Mode 11 is reserved and behaves as SEQ.
  always_comb begin
    case (w_mode[7:6])
      2'b00:   w_addr_inc = r_addr;
      2'b01:   w_addr_inc = {r_addr[ADDR_W-1:5], r_addr[4:0] + 5'd1};
      default: w_addr_inc = r_addr + ADDR_W'(1);
    endcase
  end

  assign w_rd_byte = (r_op == OP_RDMR) ? w_mode : r_mem[r_addr];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_sqi_cs_n) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_CMD;
        S_CMD: begin
          if (!w_cmd_ok)                w_state_nxt = S_IGN;
          else if (w_op_cmd == OP_RDMR) w_state_nxt = S_DUMMY;
          else if (w_op_cmd == OP_WRMR) w_state_nxt = S_WR;
          else                          w_state_nxt = S_ADDR;
        end
        S_ADDR:  if (r_cnt == 8'd0) w_state_nxt = (r_op == OP_WR) ? S_WR : S_DUMMY;
        S_DUMMY: if (r_cnt == 8'd0) w_state_nxt = S_RD;
        S_RD, S_WR, S_IGN: w_state_nxt = r_state;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output data is registered: the nibble computed here appears in the following cycle.
  always_comb begin
    w_sio_nxt    = 4'h0;
    w_sio_en_nxt = 1'b0;
    w_mem_we     = 1'b0;
    w_mode_we    = 1'b0;
    w_adv        = 1'b0;
    if (!i_sqi_cs_n) begin
      case (r_state)
        S_DUMMY: begin
          if (r_cnt == 8'd0) begin
            w_sio_en_nxt = 1'b1;
            w_sio_nxt    = w_rd_byte[7:4];
          end
        end
        S_RD: begin
          w_sio_en_nxt = 1'b1;
          w_sio_nxt    = r_half ? w_rd_byte[7:4] : w_rd_byte[3:0];
          w_adv        = !r_half && (r_op == OP_RD);
        end
        S_WR: begin
          if (r_half) begin
            w_mem_we  = (r_op == OP_WR);
            w_mode_we = (r_op == OP_WRMR);
            w_adv     = (r_op == OP_WR);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op       <= OP_RD;
      r_cmd_hi   <= 4'h0;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_half     <= 1'b0;
      r_wdata_hi <= 4'h0;
      r_sio      <= 4'h0;
      r_sio_en   <= 1'b0;
    end else begin
      r_sio    <= w_sio_nxt;
      r_sio_en <= w_sio_en_nxt;
      if (i_sqi_cs_n) begin
        r_half <= 1'b0;
        r_cnt  <= 8'd0;
      end else begin
        case (r_state)
          S_IDLE: r_cmd_hi <= i_sqi_sio;
          S_CMD: begin
            r_op   <= w_op_cmd;
            r_half <= 1'b0;
            r_cnt  <= (w_op_cmd == OP_RDMR) ? DUMMY_LAST : ADDR_LAST;
          end
          S_ADDR: begin
            r_addr <= {r_addr[ADDR_W-5:0], i_sqi_sio};
            r_cnt  <= (r_cnt == 8'd0) ? DUMMY_LAST : r_cnt - 8'd1;
          end
          S_DUMMY: begin
            r_cnt  <= r_cnt - 8'd1;
            r_half <= 1'b0;
          end
          S_RD: r_half <= ~r_half;
          S_WR: begin
            if (!r_half) r_wdata_hi <= i_sqi_sio;
            r_half <= ~r_half;
          end
          default: ;
        endcase
        if (w_adv) r_addr <= w_addr_inc;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_mem_we) r_mem[r_addr] <= {r_wdata_hi, i_sqi_sio};
  end

  assign o_sqi_sio    = r_sio;
  assign o_sqi_sio_en = r_sio_en;

endmodule

// File: tb/tb_idli_sqi_resp.sv
// Bench for idli_sqi_resp: directed protocol cases plus random write/read-back against a byte-array model.
// Mode-register cases run when IDLI_SQI_RESP_MODE_REG_EN is defined.
module tb_idli_sqi_resp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] sio_i = 4'h0;
  logic [3:0] sio_o;
  logic       sio_en;

  int errors = 0;
  int checks = 0;

  bit [7:0]   mdl [0:65535];
  bit [7:0]   mdl_mode = 8'h80;
  logic [3:0] tx_q[$];
  bit [7:0]   wr_q[$];

  always #5 clk = ~clk;

  idli_sqi_resp dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sqi_cs_n   (cs_n),
    .i_sqi_sio    (sio_i),
    .o_sqi_sio    (sio_o),
    .o_sqi_sio_en (sio_en)
  );

  function automatic bit [15:0] addr_at(bit [15:0] a, int n);
    bit [15:0] r = a;
    for (int i = 0; i < n; i++) begin
      case (mdl_mode[7:6])
        2'b00:   r = r;
        2'b01:   r = (r & 16'hFFE0) | ((r + 16'd1) & 16'h001F);
        default: r = r + 16'd1;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input bit [7:0] b);
    tx_q.push_back(b[7:4]);
    tx_q.push_back(b[3:0]);
  endtask

  task automatic push_addr(input bit [15:0] a);
    push_byte(a[15:8]);
    push_byte(a[7:0]);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(4'($urandom));
  endtask

  // Plays tx_q with cs_n low, raises cs_n for one cycle, and checks every cycle's outputs.
  // Read data is expected from cycle dstart for nrd bytes; rst_at pulses reset in that cycle.
  task automatic run(input int dstart, input int nrd, input int rst_at,
                     input bit [15:0] a, input bit is_mode);
    int L = tx_q.size();
    int j;
    bit [7:0] b;
    bit exp_en;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      exp_en = (nrd > 0) && (k >= dstart) && (rst_at < 0 || k <= rst_at);
      chk("sio_en", {7'b0, sio_en}, {7'b0, exp_en});
      if (exp_en) begin
        j = k - dstart;
        b = is_mode ? mdl_mode : mdl[addr_at(a, j / 2)];
        chk("sio_data", {4'h0, sio_o}, {4'h0, ((j % 2) == 0) ? b[7:4] : b[3:0]});
      end else if (k == 0) begin
        chk("sio_idle", {4'h0, sio_o}, 8'h00);
      end
      if (k < L) begin
        cs_n  = 1'b0;
        sio_i = tx_q[k];
      end else begin
        cs_n  = 1'b1;
        sio_i = 4'h0;
      end
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
    end
    tx_q.delete();
  endtask

  task automatic do_write(input bit [15:0] a);
    push_byte(8'h02);
    push_addr(a);
    foreach (wr_q[i]) push_byte(wr_q[i]);
    run(0, 0, -1, a, 1'b0);
    foreach (wr_q[i]) mdl[addr_at(a, i)] = wr_q[i];
    wr_q.delete();
  endtask

  task automatic do_read(input bit [15:0] a, input int n);
    push_byte(8'h03);
    push_addr(a);
    push_rand(2 + 2 * n - 1);
    run(8, n, -1, a, 1'b0);
  endtask

  initial begin
    bit [15:0] ra;
    int rn;

    repeat (3) @(negedge clk);
    chk("rst_en", {7'b0, sio_en}, 8'h00);
    chk("rst_sio", {4'h0, sio_o}, 8'h00);
    rst_n = 1'b1;

    wr_q = '{8'hA5, 8'h3C};
    do_write(16'h1234);
    do_read(16'h1234, 2);

    wr_q = '{8'h11, 8'h22};
    do_write(16'hFFFF);
    do_read(16'hFFFF, 2);
    do_read(16'h0000, 1);

    wr_q = '{8'h5E};
    do_write(16'h0010);
    push_byte(8'h02);
    push_addr(16'h0010);
    tx_q.push_back(4'h7);
    run(0, 0, -1, 16'h0010, 1'b0);
    do_read(16'h0010, 1);

    push_byte(8'h9F);
    push_rand(8);
    run(0, 0, -1, 16'h0000, 1'b0);
    do_read(16'h1234, 2);

    // Reset pulse during the read data phase.
    push_byte(8'h03);
    push_addr(16'h1234);
    push_rand(4);
    run(8, 2, 9, 16'h1234, 1'b0);
    do_read(16'h1234, 2);

`ifdef IDLI_SQI_RESP_MODE_REG_EN
    push_byte(8'h01);
    push_byte(8'h40);
    run(0, 0, -1, 16'h0000, 1'b0);
    mdl_mode = 8'h40;
    wr_q = '{8'hAA, 8'hBB};
    do_write(16'h001F);
    chk("page_wrap_mdl", mdl[16'h0000], 8'hBB);
    do_read(16'h001F, 2);
    do_read(16'h0000, 1);
    push_byte(8'h05);
    push_rand(2 + 2 * 3 - 1);
    run(4, 3, -1, 16'h0000, 1'b1);

    push_byte(8'h01);
    push_byte(8'h00);
    run(0, 0, -1, 16'h0000, 1'b0);
    mdl_mode = 8'h00;
    wr_q = '{8'h11, 8'h22};
    do_write(16'h0050);
    do_read(16'h0050, 2);

    push_byte(8'h01);
    push_byte(8'h80);
    run(0, 0, -1, 16'h0000, 1'b0);
    mdl_mode = 8'h80;
`else
    push_byte(8'h05);
    push_rand(7);
    run(0, 0, -1, 16'h0000, 1'b0);
    push_byte(8'h01);
    push_byte(8'h40);
    run(0, 0, -1, 16'h0000, 1'b0);
    do_read(16'h0010, 1);
`endif

    for (int it = 0; it < 8; it++) begin
      ra = 16'($urandom);
      if (it % 3 == 0) ra = 16'hFFFD + 16'($urandom_range(0, 2));
      rn = $urandom_range(1, 4);
      for (int i = 0; i < rn; i++) wr_q.push_back(8'($urandom));
      do_write(ra);
      do_read(ra, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
